// File: rtl/riscv_ctrl_pkg.sv
// Shared definitions for the multicycle RISC-V control sequencer:
// opcode constants, ALUOp encodings, FSM state enum and opcode class bundle.
package riscv_ctrl_pkg;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_SD  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        EXECUTE,
        MEMORY,
        WRITEBACK,
        TRAP
    } state_t;

    // One-hot-ish classification of an opcode; exactly one field is set.
    typedef struct packed {
        logic is_r;
        logic is_ld;
        logic is_sd;
        logic is_beq;
        logic illegal;
    } op_class_t;

endpackage

// File: rtl/multicycle_controller_if.sv
// Control/handshake bundle between the multicycle controller and the datapath.
// Handshake: a memory request (instrRead / memoryRead / memoryWrite) is held
// high until the matching ready is seen high in the same cycle; that cycle
// completes the transfer (zero-wait allowed). Ready outside a request is ignored.
interface multicycle_controller_if;

    logic [6:0] opcode;
    logic       instrReady;
    logic       memoryReady;

    logic       instrRead;
    logic       irWrite;
    logic       pcWrite;
    logic       branch;
    logic       regWrite;
    logic       memoryToRegister;
    logic       ALUSrc;
    logic       memoryRead;
    logic       memoryWrite;
    logic [1:0] ALUOp;
    logic       trap;

    // Controller side.
    modport master (
        input  opcode, instrReady, memoryReady,
        output instrRead, irWrite, pcWrite, branch, regWrite, memoryToRegister,
               ALUSrc, memoryRead, memoryWrite, ALUOp, trap
    );

    // Datapath / memory side.
    modport slave (
        output opcode, instrReady, memoryReady,
        input  instrRead, irWrite, pcWrite, branch, regWrite, memoryToRegister,
               ALUSrc, memoryRead, memoryWrite, ALUOp, trap
    );

endinterface

// File: rtl/opcode_class_decoder.sv
// Combinational classification of a 7-bit RISC-V opcode into the four
// supported instruction classes, everything else flagged illegal.
module opcode_class_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    output op_class_t  op_class
);

    // Map opcode to its class; unknown opcodes are illegal.
    always_comb begin
        op_class = '0;
        case (opcode)
            OP_R:    op_class.is_r    = 1'b1;
            OP_LD:   op_class.is_ld   = 1'b1;
            OP_SD:   op_class.is_sd   = 1'b1;
            OP_BEQ:  op_class.is_beq  = 1'b1;
            default: op_class.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle FSM sequencing FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK for R, LD,
// SD and BEQ. Memory waits are bounded by MEM_WAIT_MAX; illegal opcodes and
// timeouts land in a sticky TRAP state that only reset leaves.
module multicycle_controller
    import riscv_ctrl_pkg::*;
#(
    parameter int MEM_WAIT_MAX = 15
)(
    input  logic                    clock,
    input  logic                    resetN,
    multicycle_controller_if.master bus,
    output state_t                  state_dbg
);

    localparam int WCW = $clog2(MEM_WAIT_MAX + 1);

    state_t         state_q, state_d;
    logic [WCW-1:0] wait_count_q, wait_count_d;
    logic [WCW-1:0] wait_count_inc;
    logic [6:0]     opcode_q, opcode_d;
    logic [6:0]     dec_opcode;
    op_class_t      op_class;

    // In DECODE the live opcode decides the branch; elsewhere the latched copy
    // drives the outputs so later IR/opcode changes cannot glitch them.
    assign dec_opcode     = (state_q == DECODE) ? bus.opcode : opcode_q;
    assign wait_count_inc = wait_count_q + WCW'(1);
    assign state_dbg      = state_q;

    opcode_class_decoder u_decoder (
        .opcode   (dec_opcode),
        .op_class (op_class)
    );

    // State, wait counter and opcode latch registers.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_q      <= IDLE;
            wait_count_q <= '0;
            opcode_q     <= '0;
        end else begin
            state_q      <= state_d;
            wait_count_q <= wait_count_d;
            opcode_q     <= opcode_d;
        end
    end

    // Next-state, wait counting and control outputs decoded from the state.
    always_comb begin
        state_d              = state_q;
        wait_count_d         = wait_count_q;
        opcode_d             = opcode_q;
        bus.instrRead        = 1'b0;
        bus.irWrite          = 1'b0;
        bus.pcWrite          = 1'b0;
        bus.branch           = 1'b0;
        bus.regWrite         = 1'b0;
        bus.memoryToRegister = 1'b0;
        bus.ALUSrc           = 1'b0;
        bus.memoryRead       = 1'b0;
        bus.memoryWrite      = 1'b0;
        bus.ALUOp            = ALU_ADD;
        bus.trap             = 1'b0;

        case (state_q)
            IDLE: begin
                state_d = FETCH;
            end
            FETCH: begin
                bus.instrRead = 1'b1;
                if (bus.instrReady) begin
                    bus.irWrite = 1'b1;
                    bus.pcWrite = 1'b1;
                    state_d     = DECODE;
                end else if (wait_count_inc == WCW'(MEM_WAIT_MAX)) begin
                    state_d = TRAP;
                end else begin
                    wait_count_d = wait_count_inc;
                end
            end
            DECODE: begin
                opcode_d = bus.opcode;
                state_d  = op_class.illegal ? TRAP : EXECUTE;
            end
            EXECUTE: begin
                if (op_class.is_r) begin
                    bus.ALUOp = ALU_FUNCT;
                    state_d   = WRITEBACK;
                end else if (op_class.is_ld || op_class.is_sd) begin
                    bus.ALUSrc = 1'b1;
                    bus.ALUOp  = ALU_ADD;
                    state_d    = MEMORY;
                end else if (op_class.is_beq) begin
                    bus.ALUOp  = ALU_SUB;
                    bus.branch = 1'b1;
                    state_d    = FETCH;
                end else begin
                    state_d = TRAP;
                end
            end
            MEMORY: begin
                bus.ALUSrc      = 1'b1;
                bus.memoryRead  = op_class.is_ld;
                bus.memoryWrite = op_class.is_sd;
                if (bus.memoryReady) begin
                    state_d = op_class.is_ld ? WRITEBACK : FETCH;
                end else if (wait_count_inc == WCW'(MEM_WAIT_MAX)) begin
                    state_d = TRAP;
                end else begin
                    wait_count_d = wait_count_inc;
                end
            end
            WRITEBACK: begin
                bus.regWrite         = 1'b1;
                bus.memoryToRegister = op_class.is_ld;
                state_d              = FETCH;
            end
            TRAP: begin
                bus.trap = 1'b1;
            end
            default: begin
                state_d = TRAP;
            end
        endcase

        // Every state change starts the next wait from zero.
        if (state_d != state_q) begin
            wait_count_d = '0;
        end
    end

endmodule
